// File: rtl/sfpu_mul_arb.sv
// Arbiter and sequencer for the shared 24x24 FPU multiplier. It grants one of two clients,
// drives the DSP from registered operands for LAT cycles, then returns the registered product.
module sfpu_mul_arb #(
  parameter int LAT = 1,
  parameter bit RR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [23:0] a0,
  input  logic [23:0] b0,
  output logic        ack0,
  output logic        vld0,
  input  logic        req1,
  input  logic [23:0] a1,
  input  logic [23:0] b1,
  output logic        ack1,
  output logic        vld1,
  output logic [47:0] p_out,
  output logic        busy,
  output logic        gnt_id,
  output logic [23:0] mul_a,
  output logic [23:0] mul_b,
  input  logic [47:0] mul_p
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL      = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  logic [0:0] state;
  logic [1:0] cnt;
  logic       last;
  logic       any_req;
  logic       win;

  assign any_req = req0 | req1;

  // On a tie, round-robin favours whoever did not win last; fixed priority favours requester 0.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = RR ? ~last : 1'b0;
    end else begin
      win = req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      last   <= 1'b1;
      busy   <= 1'b0;
      gnt_id <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      vld0   <= 1'b0;
      vld1   <= 1'b0;
      p_out  <= 48'd0;
      mul_a  <= 24'd0;
      mul_b  <= 24'd0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
      if (state == IDLE) begin
        if (any_req) begin
          state  <= MUL;
          busy   <= 1'b1;
          cnt    <= CNT_INIT;
          gnt_id <= win;
          last   <= win;
          mul_a  <= win ? a1 : a0;
          mul_b  <= win ? b1 : b0;
          ack0   <= ~win;
          ack1   <= win;
        end
      end else begin
        // The capture edge never grants, so a still-held request waits one more cycle.
        if (cnt != 2'd0) begin
          cnt <= cnt - 2'd1;
        end else begin
          p_out <= mul_p;
          vld0  <= ~gnt_id;
          vld1  <= gnt_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfpu_mul_arb.sv
// Bench for sfpu_mul_arb: three parameter sets run side by side, each against a
// timestamp-level reference model that feeds ack and vld scoreboards.
module tb_sfpu_mul_arb;

  typedef struct packed {
    logic        id;
    int unsigned cyc;
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } txn_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input int g, input string name, input logic [63:0] act,
                             input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL cfg%0d %s actual=0x%0h expected=0x%0h", g, name, act, exp_v);
    end
  endtask

  function automatic logic [23:0] rndOp();
    case ($urandom_range(0, 3))
      0:       return 24'hFFFFFF;
      1:       return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int L = (g == 1) ? 3 : 1;
    localparam bit R = (g == 2) ? 1'b0 : 1'b1;

    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [23:0] a0 = 24'd0;
    logic [23:0] b0 = 24'd0;
    logic [23:0] a1 = 24'd0;
    logic [23:0] b1 = 24'd0;
    logic        ack0, ack1, vld0, vld1, busy, gnt_id;
    logic [23:0] mul_a, mul_b;
    logic [47:0] p_out, mul_p;

    txn_t        ack_q[$];
    txn_t        vld_q[$];
    txn_t        m_cur;
    txn_t        m_tmp;
    txn_t        mon_t;
    int unsigned cyc = 0;
    logic        m_inflight = 1'b0;
    logic        m_last = 1'b1;
    logic        m_gnt = 1'b0;
    logic [23:0] m_a = 24'd0;
    logic [23:0] m_b = 24'd0;
    logic [47:0] m_p = 48'd0;

    // Behavioural stand-in for the DSP.
    assign mul_p = {24'd0, mul_a} * {24'd0, mul_b};

    sfpu_mul_arb #(.LAT(L), .RR(R)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .ack0(ack0), .vld0(vld0),
      .req1(req1), .a1(a1), .b1(b1), .ack1(ack1), .vld1(vld1),
      .p_out(p_out), .busy(busy), .gnt_id(gnt_id),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    // Reference: a grant at cycle c owns the multiplier until capture at c+L.
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ack_q.delete();
        vld_q.delete();
        m_inflight = 1'b0;
        m_last = 1'b1;
        m_gnt = 1'b0;
        m_a = 24'd0;
        m_b = 24'd0;
        m_p = 48'd0;
      end else begin
        cyc++;
        if (m_inflight) begin
          if (cyc == m_cur.cyc + L) begin
            m_p = m_cur.p;
            m_inflight = 1'b0;
          end
        end else if (req0 || req1) begin
          m_cur.id = (req0 && req1) ? (R ? !m_last : 1'b0) : req1;
          m_cur.a = m_cur.id ? a1 : a0;
          m_cur.b = m_cur.id ? b1 : b0;
          m_cur.p = 48'(longint'(m_cur.a) * longint'(m_cur.b));
          m_cur.cyc = cyc;
          m_last = m_cur.id;
          m_gnt = m_cur.id;
          m_a = m_cur.a;
          m_b = m_cur.b;
          m_inflight = 1'b1;
          ack_q.push_back(m_cur);
          m_tmp = m_cur;
          m_tmp.cyc = cyc + L;
          vld_q.push_back(m_tmp);
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput(g, "busy", 64'(busy), 64'(m_inflight));
        checkOutput(g, "gnt_id", 64'(gnt_id), 64'(m_gnt));
        checkOutput(g, "p_out", 64'(p_out), 64'(m_p));
        checkOutput(g, "mul_a", 64'(mul_a), 64'(m_a));
        checkOutput(g, "mul_b", 64'(mul_b), 64'(m_b));
        checkOutput(g, "ack_pair", 64'(ack0 & ack1), 64'd0);
        checkOutput(g, "vld_pair", 64'(vld0 & vld1), 64'd0);
        if (ack0 || ack1) begin
          if (ack_q.size() == 0) begin
            checkOutput(g, "ack_spurious", 64'({ack1, ack0}), 64'd0);
          end else begin
            mon_t = ack_q.pop_front();
            checkOutput(g, "ack_id", 64'(ack1), 64'(mon_t.id));
            checkOutput(g, "ack_cycle", 64'(cyc), 64'(mon_t.cyc));
          end
        end else if (ack_q.size() != 0 && ack_q[0].cyc <= cyc) begin
          mon_t = ack_q.pop_front();
          checkOutput(g, "ack_missing", 64'({ack1, ack0}), mon_t.id ? 64'd2 : 64'd1);
        end
        if (vld0 || vld1) begin
          if (vld_q.size() == 0) begin
            checkOutput(g, "vld_spurious", 64'({vld1, vld0}), 64'd0);
          end else begin
            mon_t = vld_q.pop_front();
            checkOutput(g, "vld_id", 64'(vld1), 64'(mon_t.id));
            checkOutput(g, "vld_cycle", 64'(cyc), 64'(mon_t.cyc));
            checkOutput(g, "vld_product", 64'(p_out), 64'(mon_t.p));
          end
        end else if (vld_q.size() != 0 && vld_q[0].cyc <= cyc) begin
          mon_t = vld_q.pop_front();
          checkOutput(g, "vld_missing", 64'({vld1, vld0}), mon_t.id ? 64'd2 : 64'd1);
        end
      end
    end

    task automatic applyStimulus(input logic r0, input logic [23:0] x0, input logic [23:0] y0,
                                 input logic r1, input logic [23:0] x1, input logic [23:0] y1);
      @(negedge clk);
      req0 = r0;
      a0 = x0;
      b0 = y0;
      req1 = r1;
      a1 = x1;
      b1 = y1;
    endtask

    task automatic waitAck(input logic id);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = id ? ack1 : ack0;
      end
      checkOutput(g, id ? "ack1_wait" : "ack0_wait", 64'(seen), 64'd1);
    endtask

    task automatic waitIdle();
      int n;
      n = 0;
      while ((m_inflight || ack_q.size() != 0 || vld_q.size() != 0) && n < 60) begin
        @(negedge clk);
        n++;
      end
      checkOutput(g, "drain", 64'(vld_q.size() + ack_q.size()), 64'd0);
      @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
      checkOutput(g, {tag, "_ack"}, 64'({ack1, ack0}), 64'd0);
      checkOutput(g, {tag, "_vld"}, 64'({vld1, vld0}), 64'd0);
      checkOutput(g, {tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput(g, {tag, "_gnt_id"}, 64'(gnt_id), 64'd0);
      checkOutput(g, {tag, "_p_out"}, 64'(p_out), 64'd0);
      checkOutput(g, {tag, "_mul_a"}, 64'(mul_a), 64'd0);
      checkOutput(g, {tag, "_mul_b"}, 64'(mul_b), 64'd0);
    endtask

    initial begin
      int   n;
      int   guard;
      logic last_id;
      repeat (3) @(negedge clk);
      checkResetValues("por");
      rst_n = 1'b1;

      // Tie straight out of reset: requester 0 goes first in both arbitration modes.
      applyStimulus(1'b1, 24'h800000, 24'h000003, 1'b1, 24'h123456, 24'h000010);
      waitAck(1'b0);
      req0 = 1'b0;
      waitAck(1'b1);
      req1 = 1'b0;
      waitIdle();

      applyStimulus(1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'd0, 24'd0);
      waitAck(1'b0);
      req0 = 1'b0;
      waitIdle();

      applyStimulus(1'b0, 24'd0, 24'd0, 1'b1, 24'h000002, 24'h000005);
      waitAck(1'b1);
      req1 = 1'b0;
      waitIdle();

      // Both held: alternation under round-robin, requester 0 only under fixed priority.
      applyStimulus(1'b1, 24'h000011, 24'h000013, 1'b1, 24'h000017, 24'h00001D);
      n = 0;
      guard = 0;
      last_id = 1'b0;
      while (n < 6 && guard < 100) begin
        @(negedge clk);
        guard++;
        if (ack0 || ack1) begin
          checkOutput(g, "hold_order", 64'(ack1), 64'(R ? n % 2 : 0));
          last_id = ack1;
          n++;
        end
      end
      checkOutput(g, "hold_grants", 64'(n), 64'd6);
      req0 = 1'b0;
      if (!last_id) waitAck(1'b1);
      req1 = 1'b0;
      waitIdle();

      // Back-to-back: req0 stays high with fresh operands after its first ack.
      applyStimulus(1'b1, 24'h000005, 24'h000006, 1'b0, 24'd0, 24'd0);
      waitAck(1'b0);
      a0 = 24'h000007;
      b0 = 24'h000009;
      waitAck(1'b0);
      req0 = 1'b0;
      waitIdle();

      // Reset one cycle after the ack discards the operation.
      applyStimulus(1'b0, 24'd0, 24'd0, 1'b1, 24'h000ABC, 24'h000DEF);
      waitAck(1'b1);
      req1 = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkResetValues("mid");
      @(negedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(1'b1, 24'h000021, 24'h000043, 1'b0, 24'd0, 24'd0);
      waitAck(1'b0);
      req0 = 1'b0;
      waitIdle();

      fork
        begin
          for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            a0 = rndOp();
            b0 = rndOp();
            req0 = 1'b1;
            waitAck(1'b0);
            req0 = 1'b0;
          end
        end
        begin
          for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            a1 = rndOp();
            b1 = rndOp();
            req1 = 1'b1;
            waitAck(1'b1);
            req1 = 1'b0;
          end
        end
      join
      waitIdle();
      done_cnt++;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (done_cnt < 3 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput(3, "all_done", 64'(done_cnt), 64'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfpu_mul_arb.md
# sfpu_mul_arb

Two-requester arbiter and sequencer for the shared 24x24 unsigned multiplier used by the single-precision FPU (`sfpu_dsp24`, 48-bit product). It accepts operand pairs from two clients, typically the FPU mantissa-multiply path and the integer multiply unit. It grants one client at a time, drives the multiplier from registered operands, waits a configurable number of cycles, then returns the registered product to the granted client with a valid pulse.

## Interface
- `LAT`, default 1: cycles from operand latch to product capture, range 1..4. Values above 1 allow a multicycle path through the DSP.
- `RR`, default 1: arbitration mode. 1 = round-robin; 0 = fixed priority, requester 0 wins.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0` in 1: requester 0 request; hold `a0`/`b0` stable while high.
- `a0` in 24: requester 0 operand a.
- `b0` in 24: requester 0 operand b.
- `ack0` out 1: one-cycle pulse meaning requester 0's operands were latched.
- `vld0` out 1: one-cycle pulse meaning `p_out` holds requester 0's product.
- `req1`, `a1`, `b1`, `ack1`, `vld1`: same as above, for requester 1.
- `p_out` out 48: registered product; held until the next capture.
- `busy` out 1: high from grant until product capture.
- `gnt_id` out 1: id of the current or last granted requester.
- `mul_a` out 24: multiplier operand a, from the operand register.
- `mul_b` out 24: multiplier operand b, from the operand register.
- `mul_p` in 48: multiplier product (combinational `a*b`).

## Operation
- The FSM has two states, IDLE and MUL. The down-counter `cnt` is 2 bits wide.
- **IDLE, no req:** remain in IDLE.
- **IDLE, any req at edge E0:** select the winner.
  - Latch the winner's a/b into `mul_a`/`mul_b`.
  - Set `gnt_id`; assert that requester's ack for exactly one cycle.
  - Set `busy=1`, `cnt=LAT-1`, and go to MUL.
- **MUL, cnt≠0:** decrement `cnt`. Requests are ignored.
- **MUL, cnt=0:**
  - `p_out<=mul_p`.
  - Assert `vld[gnt_id]` for exactly one cycle.
  - Set `busy=0` and return to IDLE. No grant is made on this same edge.
- **Arbitration, RR=1:** with a single request, that requester wins. With both requesting, the winner is `~last`. `last` updates to the winner on each grant and resets to 1, so requester 0 wins the first tie.
- **Arbitration, RR=0:** `req0` always wins a tie; `last` is unused.
- **Request protocol:** the requester drops req on the edge after it sees ack. If req is still high when the FSM returns to IDLE, that is a new request and is re-granted.
- `mul_a`/`mul_b` hold their last operands while in IDLE, which avoids DSP toggling. `p_out` holds its value until the next capture.
- Unsigned only. Full 48-bit product; no truncation or rounding in this block.
- `ack` and `vld` are never asserted for both requesters in the same cycle. `ack` and `vld` of the same requester are never coincident.

## Timing
- All outputs are registered. Reset values: `ack0=ack1=vld0=vld1=0`, `busy=0`, `gnt_id=0`, `p_out=0`, `mul_a=mul_b=0`, state IDLE, `cnt=0`, `last=1`.
- **Grant edge E0:** ack is visible during cycle E0..E1.
- **Capture edge E0+LAT:** vld is visible for one cycle after it.
- **Next grant:** earliest at E0+LAT+1, giving a throughput of 1 operation per LAT+1 cycles.
- **Reset mid-operation:** `rst_n` low at any point returns all state and outputs to reset values immediately (asynchronous). The in-flight operation is discarded and no vld is produced. After release, the first rising edge with a req present is treated as E0.
- A request arriving during MUL waits; it is not lost while held high.

## Test plan
- **Single request, LAT=1:** `req0` with a0=b0=0xFFFFFF.
  - `ack0` appears 1 cycle after the sampling edge.
  - `vld0` follows 1 cycle after `ack0`, with `p_out=0xFFFFFE000001`.
  - `busy` is high for exactly 1 cycle.
- **Simultaneous requests, RR=1, out of reset:** `req0`: 0x800000×0x000003; `req1`: 0x123456×0x000010.
  - Requester 0 is served first: `vld0` with `p_out=0x1800000`.
  - Then `ack1`, then `vld1` with `p_out=0x1234560`.
- **Both requests held continuously, RR=1:** the grants alternate 0,1,0,1. For RR=0, only requester 0 is ever granted (requester 1 starves).
- **LAT=3:** `req1` 0x000002×0x000005. `ack1` at E0; `vld1` exactly 3 cycles later with `p_out=0xA`; `busy` is high for 3 cycles.
- **Back-to-back:** `req0` held high through vld with new operands 0x000007×0x000009. A second `ack0` arrives one cycle after `vld0`, and the second `vld0` gives `p_out=0x3F`.
- **Reset mid-operation, LAT=3:** `rst_n` pulsed low 1 cycle after ack.
  - No vld is produced; all outputs read their reset values.
  - A subsequent request completes normally.
